arp_rx_parser: RTL

- Receive-side ARP engine. Consumes Ethernet frames byte-by-byte from the RX MAC (destination MAC onward, FCS already stripped) and validates ARP fields.
- For an ARP request targeting the local IP, it raises arp_resp_start toward the ARP TX arbiter and holds the requester's MAC/IP for the response builder.
- For an ARP reply, it pulses arp_reply_valid with the sender's MAC/IP for the ARP cache.

---
 rtl/arp_rx_parser.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/arp_rx_parser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arp_rx_parser : ARP RX field validator, SHA/SPA capture, request/reply hand-off.
// Optional drop counter: define ARP_RX_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module arp_rx_parser #(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [47:0]           local_mac,
  input  logic [31:0]           local_ip,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  input  logic                  arp_data_tx_done,
  output logic                  arp_resp_start,
  output logic                  arp_reply_valid,
  output logic [47:0]           peer_mac,
  output logic [31:0]           peer_ip,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_PAD    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DECIDE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  off_q, off_d;
  logic        bc_ok_q, bc_ok_d, uc_ok_q, uc_ok_d;
  logic        is_req_q, is_req_d;
  logic        tuser_q, tuser_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic        tready_q;
  logic        resp_start_q, resp_start_d;
  logic        reply_valid_q, reply_valid_d;
  logic [47:0] peer_mac_q, peer_mac_d;
  logic [31:0] peer_ip_q, peer_ip_d;

  logic        w_accept, w_sof, w_byte_bad, w_drop_rx, w_drop_dec;
  logic [5:0]  w_off;
  logic [7:0]  w_mac_byte, w_ip_byte;

  assign w_accept = s_axis_tvalid & tready_q;
  // A beat arriving while DECIDE resolves the previous frame starts the next one.
  assign w_sof    = (state_q == S_IDLE) || (state_q == S_DECIDE);
  assign w_off    = w_sof ? 6'd0 : off_q;

  always_comb begin
    case (w_off[2:0])
      3'd0:    w_mac_byte = local_mac[47:40];
      3'd1:    w_mac_byte = local_mac[39:32];
      3'd2:    w_mac_byte = local_mac[31:24];
      3'd3:    w_mac_byte = local_mac[23:16];
      3'd4:    w_mac_byte = local_mac[15:8];
      default: w_mac_byte = local_mac[7:0];
    endcase
    // TPA offsets 38..41 have low bits 2,3,0,1
    case (w_off[1:0])
      2'd2:    w_ip_byte = local_ip[31:24];
      2'd3:    w_ip_byte = local_ip[23:16];
      2'd0:    w_ip_byte = local_ip[15:8];
      default: w_ip_byte = local_ip[7:0];
    endcase
  end

  always_comb begin
    w_byte_bad = 1'b0;
    bc_ok_d    = bc_ok_q;
    uc_ok_d    = uc_ok_q;
    is_req_d   = is_req_q;
    sha_d      = sha_q;
    spa_d      = spa_q;
    if (w_accept && (w_sof || (state_q == S_RECV))) begin
      case (w_off)
        6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
          bc_ok_d    = (w_sof | bc_ok_q) & (s_axis_tdata == 8'hFF);
          uc_ok_d    = (w_sof | uc_ok_q) & (s_axis_tdata == w_mac_byte);
          w_byte_bad = !(bc_ok_d || uc_ok_d);
        end
        6'd12: w_byte_bad = (s_axis_tdata != 8'h08);
        6'd13: w_byte_bad = (s_axis_tdata != 8'h06);
        6'd14: w_byte_bad = (s_axis_tdata != 8'h00);
        6'd15: w_byte_bad = (s_axis_tdata != 8'h01);
        6'd16: w_byte_bad = (s_axis_tdata != 8'h08);
        6'd17: w_byte_bad = (s_axis_tdata != 8'h00);
        6'd18: w_byte_bad = (s_axis_tdata != 8'h06);
        6'd19: w_byte_bad = (s_axis_tdata != 8'h04);
        6'd20: w_byte_bad = (s_axis_tdata != 8'h00);
        6'd21: begin
          if (s_axis_tdata == 8'h01)      is_req_d = 1'b1;
          else if (s_axis_tdata == 8'h02) is_req_d = 1'b0;
          else                            w_byte_bad = 1'b1;
        end
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27: sha_d = {sha_q[39:0], s_axis_tdata};
        6'd28, 6'd29, 6'd30, 6'd31:               spa_d = {spa_q[23:0], s_axis_tdata};
        6'd38, 6'd39, 6'd40, 6'd41:               w_byte_bad = (s_axis_tdata != w_ip_byte);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    tuser_d       = tuser_q;
    w_drop_rx     = 1'b0;
    w_drop_dec    = 1'b0;
    resp_start_d  = resp_start_q;
    reply_valid_d = 1'b0;
    peer_mac_d    = peer_mac_q;
    peer_ip_d     = peer_ip_q;

    if (arp_data_tx_done && resp_start_q) resp_start_d = 1'b0;

    case (state_q)
      S_IDLE, S_DECIDE: begin
        if (state_q == S_DECIDE) begin
          state_d = S_IDLE;
          if (tuser_q) begin
            w_drop_dec = 1'b1;
          end else if (is_req_q) begin
            // A done pulse in the same cycle wins over a new request.
            if (resp_start_q || arp_data_tx_done) begin
              w_drop_dec = 1'b1;
            end else begin
              peer_mac_d   = sha_q;
              peer_ip_d    = spa_q;
              resp_start_d = 1'b1;
            end
          end else if (resp_start_q) begin
            w_drop_dec = 1'b1;
          end else begin
            peer_mac_d    = sha_q;
            peer_ip_d     = spa_q;
            reply_valid_d = 1'b1;
          end
        end
        if (w_accept) begin
          off_d = 6'd1;
          if (s_axis_tlast) begin
            w_drop_rx = 1'b1;
            state_d   = S_IDLE;
          end else if (w_byte_bad) begin
            w_drop_rx = 1'b1;
            state_d   = S_DRAIN;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_accept) begin
          if (off_q != 6'd63) off_d = off_q + 6'd1;
          if (w_byte_bad) begin
            w_drop_rx = 1'b1;
            state_d   = s_axis_tlast ? S_IDLE : S_DRAIN;
          end else if (off_q == 6'd41) begin
            tuser_d = s_axis_tuser;
            state_d = s_axis_tlast ? S_DECIDE : S_PAD;
          end else if (s_axis_tlast) begin
            w_drop_rx = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_PAD: begin
        if (w_accept && s_axis_tlast) begin
          tuser_d = s_axis_tuser;
          state_d = S_DECIDE;
        end
      end
      S_DRAIN: begin
        if (w_accept && s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      off_q         <= 6'd0;
      bc_ok_q       <= 1'b0;
      uc_ok_q       <= 1'b0;
      is_req_q      <= 1'b0;
      tuser_q       <= 1'b0;
      sha_q         <= 48'd0;
      spa_q         <= 32'd0;
      tready_q      <= 1'b0;
      resp_start_q  <= 1'b0;
      reply_valid_q <= 1'b0;
      peer_mac_q    <= 48'd0;
      peer_ip_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      bc_ok_q       <= bc_ok_d;
      uc_ok_q       <= uc_ok_d;
      is_req_q      <= is_req_d;
      tuser_q       <= tuser_d;
      sha_q         <= sha_d;
      spa_q         <= spa_d;
      tready_q      <= 1'b1;
      resp_start_q  <= resp_start_d;
      reply_valid_q <= reply_valid_d;
      peer_mac_q    <= peer_mac_d;
      peer_ip_q     <= peer_ip_d;
    end
  end

  assign s_axis_tready   = tready_q;
  assign arp_resp_start  = resp_start_q;
  assign arp_reply_valid = reply_valid_q;
  assign peer_mac        = peer_mac_q;
  assign peer_ip         = peer_ip_q;

`ifdef ARP_RX_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   w_cnt_sum;

  // Two drops can coincide: the frame resolving in DECIDE and a one-beat frame.
  always_comb begin
    w_cnt_sum  = {1'b0, drop_cnt_q} +
                 {{(DROP_CNT_W-1){1'b0}}, w_drop_rx & w_drop_dec, w_drop_rx ^ w_drop_dec};
    drop_cnt_d = w_cnt_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : w_cnt_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = w_drop_rx | w_drop_dec;
  assign drop_cnt    = '0;
`endif

endmodule
`default_nettype wire
